ram_bist: RTL and testbench
===========================

// Module: ram_bist
// PURPOSE
//   Bus initiator for the RAM stb/we/addr/ack interface: drives the RAM port
//   in place of the CPU during bring-up. Fills a word range with a
//   deterministic pattern, reads it back, compares, and reports the result.
//   Sits between a control source (switches/debug regs) and the RAM data port.
// PARAMETERS
//   SEED     32'hA5C3_0F96  XOR constant; pattern(a) = {7'b0,a[26:2]} ^ SEED
//   TIMEOUT  1023           max cycles to wait for ack per access (1..65535)
// PORTS
//   clk            in   1   system clock
//   rst_n          in   1   asynchronous reset, active low
//   start          in   1   single-cycle pulse: begin test (ignored while busy)
//   base           in   25  first word address [26:2], sampled on start
//   len            in   25  number of words, sampled on start
//   busy           out  1   test in progress
//   done           out  1   one-cycle pulse when test ends
//   pass           out  1   valid from done until next start: 1 = no errors
//   timeout        out  1   sticky until next start: an access was not acked
//   err_cnt        out  16  mismatching reads, saturates at 16'hFFFF
//   err_addr       out  25  word address of first mismatch (0 if none)
//   stb            out  1   bus request
//   we             out  1   1 = write, 0 = read
//   addr           out  25  word address [26:2]
//   data_out       out  32  write data (to RAM data_in)
//   data_in        in   32  read data (from RAM data_out), valid with ack
//   ack            in   1   access complete
// BEHAVIOUR
//   Reset: busy=0 done=0 pass=0 timeout=0 err_cnt=0 err_addr=0 stb=0 we=0
//     addr=0 data_out=0; FSM=IDLE. Reset mid-access drops stb immediately.
//   FSM: IDLE -> WR_REQ <-> WR_GAP -> RD_REQ <-> RD_GAP -> FIN -> IDLE.
//   IDLE: on start: latch base/len, clear pass/timeout/err_cnt/err_addr, busy=1,
//     word index i=0; len==0 -> FIN directly (pass=1).
//   *_REQ: stb=1, addr=base+i (mod 2^25, wraps silently), we per phase,
//     data_out=pattern(addr) in write phase; addr/we/data_out stable while stb.
//   Ack sampled in *_REQ: stb=0 next cycle (*_GAP, exactly one idle cycle),
//     i++; if i==len-1 at ack -> next phase (RD_REQ with i=0, or FIN).
//   Read compare at ack: data_in != pattern(addr) -> err_cnt++ (saturating);
//     if err_cnt was 0, err_addr=addr.
//   Timeout: wait counter resets on entry to *_REQ; ack not seen within TIMEOUT
//     cycles of stb -> stb=0, timeout=1, go FIN. Ack on the TIMEOUT-th cycle
//     counts as success.
//   FIN: done=1 for one cycle, busy=0, pass=(err_cnt==0)&&!timeout -> IDLE.
//   Access latency: stb high >=1 cycle; min 2 cycles per word (REQ+GAP);
//     total min = 4*len + 1 cycles start->done for non-wait-state RAM.
//   start while busy: ignored. ack while stb=0: ignored.
// CONFIGURATION
//   RAM_BIST_INVERT_PASS_EN defined: after the first read phase, a second
//     write+read pass over the same range with ~pattern(a); FSM adds
//     WI_REQ/WI_GAP/RI_REQ/RI_GAP; errors from both passes accumulate in
//     err_cnt; err_addr keeps first mismatch overall.
//   Not defined: single write+read pass only; those states do not exist.
// TESTING
//   Ideal RAM model, ack 1 cycle after stb, base=0x100, len=4 -> 4 writes,
//     4 reads at 0x100..0x103, pass=1, err_cnt=0, done 17 cycles after start.
//   Model corrupts bit 0 of word 0x102 -> pass=0, err_cnt=1, err_addr=0x102
//     (with INVERT_PASS_EN: err_cnt=2).
//   Model never acks, TIMEOUT=8 -> stb high 8 cycles then low, timeout=1,
//     pass=0, done pulse, busy=0.
//   len=0 -> no stb ever asserted, done 2 cycles after start, pass=1.
//   base=0x1FFFFFE, len=4 -> addresses 0x1FFFFFE,0x1FFFFFF,0x0,0x1; pass=1.
//   rst_n low during read phase with stb=1 -> stb=0 and busy=0 at once;
//     start pulsed during busy -> no effect on base/len or counters.

Source files
------------

// File: rtl/ram_bist.sv
// -----------------------------------------------------------------------------
// ram_bist
//   RAM bring-up tester. It takes over the RAM stb/we/addr/ack port and
//   works through a range of words in two phases. First it writes
//   pattern(a) = {7'b0, a} ^ SEED to every word, then it reads every word
//   back and compares it with the pattern. When it finishes it reports
//   pass/fail, the number of mismatches and the first failing word address.
//
//   Optional feature, selected by the macro RAM_BIST_INVERT_PASS_EN:
//     After the first read phase, a second write+read pass runs over the same
//     range using ~pattern(a). Errors from both passes add into err_cnt, and
//     err_addr keeps the first mismatch seen overall. When the macro is
//     undefined, only the single write+read pass exists.
//
// Parameters
//   SEED     XOR constant used to build the pattern
//   TIMEOUT  maximum number of stb cycles to wait for ack (1..65535)
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   start               one-cycle pulse that starts a test (ignored while busy)
//   base, len           first word address and word count, sampled on start
//   busy                high while a test is running
//   done                one-cycle pulse when a test ends
//   pass                result; valid from done until the next start
//   timeout             sticky flag: an access was never acked
//   err_cnt, err_addr   saturating mismatch count, first mismatching word
//   stb, we, addr       bus request, write enable, word address
//   data_out            write data
//   data_in, ack        read data (valid together with ack), access complete
// -----------------------------------------------------------------------------
module ram_bist #(
  parameter logic [31:0] SEED    = 32'hA5C3_0F96,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [24:0] base,
  input  logic [24:0] len,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        timeout,
  output logic [15:0] err_cnt,
  output logic [24:0] err_addr,
  output logic        stb,
  output logic        we,
  output logic [24:0] addr,
  output logic [31:0] data_out,
  input  logic [31:0] data_in,
  input  logic        ack
);

  // The wait counter counts from 0, so the last allowed stb cycle is TIMEOUT-1.
  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_WR_REQ,
    S_WR_GAP,
    S_RD_REQ,
    S_RD_GAP,
`ifdef RAM_BIST_INVERT_PASS_EN
    S_WI_REQ,
    S_WI_GAP,
    S_RI_REQ,
    S_RI_GAP,
`endif
    S_FIN
  } state_t;

  state_t      state_q, state_d;
  logic [24:0] base_q, base_d;
  logic [24:0] len_q, len_d;
  logic [24:0] idx_q, idx_d;
  logic [15:0] wait_q, wait_d;
  logic [15:0] err_cnt_q, err_cnt_d;
  logic [24:0] err_addr_q, err_addr_d;
  logic        timeout_q, timeout_d;
  logic        pass_q, pass_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  // Phase decode
  logic        in_write;
  logic        in_read;
  logic        in_req;
  logic        inv_phase;
  state_t      gap_st;        // state after a non-final ack in this phase
  state_t      phase_end_st;  // state after the last word of this phase

  logic [24:0] cur_addr;
  logic [31:0] pattern_w;
  logic [31:0] exp_word;
  logic        last_word;
  logic        mismatch;

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  // Word addresses wrap silently modulo 2^25.
  assign cur_addr  = base_q + idx_q;
  assign pattern_w = {7'b0, cur_addr} ^ SEED;

  // In the inverted pass every pattern bit is flipped.
  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_exp
      assign exp_word[gi] = pattern_w[gi] ^ inv_phase;
    end
  endgenerate

  assign last_word = (idx_q == (len_q - 25'd1));
  assign mismatch  = (data_in != exp_word);

  // ---------------------------------------------------------------------------
  // Phase decode: which REQ state we are in, and where it leads
  // ---------------------------------------------------------------------------
  always_comb begin
    in_write     = 1'b0;
    in_read      = 1'b0;
    inv_phase    = 1'b0;
    gap_st       = S_IDLE;
    phase_end_st = S_IDLE;
    case (state_q)
      S_WR_REQ: begin
        in_write     = 1'b1;
        gap_st       = S_WR_GAP;
        phase_end_st = S_WR_GAP;
      end
      S_RD_REQ: begin
        in_read      = 1'b1;
        gap_st       = S_RD_GAP;
`ifdef RAM_BIST_INVERT_PASS_EN
        phase_end_st = S_RD_GAP;
`else
        // The final access uses FIN as its idle cycle.
        phase_end_st = S_FIN;
`endif
      end
`ifdef RAM_BIST_INVERT_PASS_EN
      S_WI_REQ: begin
        in_write     = 1'b1;
        inv_phase    = 1'b1;
        gap_st       = S_WI_GAP;
        phase_end_st = S_WI_GAP;
      end
      S_RI_REQ: begin
        in_read      = 1'b1;
        inv_phase    = 1'b1;
        gap_st       = S_RI_GAP;
        phase_end_st = S_FIN;
      end
`endif
      default: ;
    endcase
  end

  assign in_req = in_write | in_read;

  // ---------------------------------------------------------------------------
  // Bus outputs are decoded from registered state, so an asynchronous reset
  // drops stb immediately. idx only moves on ack, so addr, we and data_out
  // stay stable while stb is high.
  // ---------------------------------------------------------------------------
  assign stb      = in_req;
  assign we       = in_write;
  assign addr     = cur_addr;
  assign data_out = in_write ? exp_word : 32'h0;

  assign busy     = busy_q;
  assign done     = done_q;
  assign pass     = pass_q;
  assign timeout  = timeout_q;
  assign err_cnt  = err_cnt_q;
  assign err_addr = err_addr_q;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    len_d      = len_q;
    idx_d      = idx_q;
    wait_d     = wait_q;
    err_cnt_d  = err_cnt_q;
    err_addr_d = err_addr_q;
    timeout_d  = timeout_q;
    pass_d     = pass_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d     = base;
          len_d      = len;
          idx_d      = 25'd0;
          wait_d     = 16'd0;
          err_cnt_d  = 16'd0;
          err_addr_d = 25'd0;
          timeout_d  = 1'b0;
          pass_d     = 1'b0;
          busy_d     = 1'b1;
          state_d    = (len == 25'd0) ? S_FIN : S_WR_REQ;
        end
      end

      S_WR_REQ,
`ifdef RAM_BIST_INVERT_PASS_EN
      S_WI_REQ,
      S_RI_REQ,
`endif
      S_RD_REQ: begin
        if (ack) begin
          wait_d = 16'd0;
          if (in_read && mismatch) begin
            if (err_cnt_q != 16'hFFFF) begin
              err_cnt_d = err_cnt_q + 16'd1;
            end
            if (err_cnt_q == 16'd0) begin
              err_addr_d = cur_addr;
            end
          end
          if (last_word) begin
            // idx returning to 0 tells the following GAP state that this
            // phase is complete.
            idx_d   = 25'd0;
            state_d = phase_end_st;
          end else begin
            idx_d   = idx_q + 25'd1;
            state_d = gap_st;
          end
        end else if (wait_q == WAIT_LAST) begin
          timeout_d = 1'b1;
          state_d   = S_FIN;
        end else begin
          wait_d = wait_q + 16'd1;
        end
      end

      // Inside a phase idx is never 0 in a GAP state, because a non-final ack
      // always increments it. So idx == 0 means the next phase starts.
      S_WR_GAP: begin
        wait_d  = 16'd0;
        state_d = (idx_q == 25'd0) ? S_RD_REQ : S_WR_REQ;
      end

      S_RD_GAP: begin
        wait_d  = 16'd0;
`ifdef RAM_BIST_INVERT_PASS_EN
        state_d = (idx_q == 25'd0) ? S_WI_REQ : S_RD_REQ;
`else
        state_d = S_RD_REQ;
`endif
      end

`ifdef RAM_BIST_INVERT_PASS_EN
      S_WI_GAP: begin
        wait_d  = 16'd0;
        state_d = (idx_q == 25'd0) ? S_RI_REQ : S_WI_REQ;
      end

      S_RI_GAP: begin
        wait_d  = 16'd0;
        state_d = S_RI_REQ;
      end
`endif

      S_FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        pass_d  = (err_cnt_q == 16'd0) && !timeout_q;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      base_q     <= 25'd0;
      len_q      <= 25'd0;
      idx_q      <= 25'd0;
      wait_q     <= 16'd0;
      err_cnt_q  <= 16'd0;
      err_addr_q <= 25'd0;
      timeout_q  <= 1'b0;
      pass_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      wait_q     <= wait_d;
      err_cnt_q  <= err_cnt_d;
      err_addr_q <= err_addr_d;
      timeout_q  <= timeout_d;
      pass_q     <= pass_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

endmodule

// File: tb/tb_ram_bist.sv
// -----------------------------------------------------------------------------
// tb_ram_bist
//   Scoreboard bench for ram_bist. It contains a small RAM with a
//   configurable number of wait states, an ack budget (used to force
//   timeouts) and optional stuck bit-0 words. The stimulus computes each
//   test's expected bus accesses and result from the behavioural rules, then
//   queues them. Two monitors pop and compare: one on every acked access and
//   one on every done pulse.
// -----------------------------------------------------------------------------
module tb_ram_bist;

  localparam int          TO      = 8;
  localparam logic [31:0] SEED_TB = 32'hA5C3_0F96;
`ifdef RAM_BIST_INVERT_PASS_EN
  localparam int          PASSES  = 2;
`else
  localparam int          PASSES  = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [24:0] base;
  logic [24:0] len;
  logic        busy;
  logic        done;
  logic        pass;
  logic        timeout;
  logic [15:0] err_cnt;
  logic [24:0] err_addr;
  logic        stb;
  logic        we;
  logic [24:0] addr;
  logic [31:0] data_out;
  logic [31:0] data_in;
  logic        ack;

  always #5 clk = ~clk;

  ram_bist #(.SEED(SEED_TB), .TIMEOUT(TO)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .base     (base),
    .len      (len),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .timeout  (timeout),
    .err_cnt  (err_cnt),
    .err_addr (err_addr),
    .stb      (stb),
    .we       (we),
    .addr     (addr),
    .data_out (data_out),
    .data_in  (data_in),
    .ack      (ack)
  );

  // ---------------------------------------------------------------------------
  // RAM model
  // ---------------------------------------------------------------------------
  logic [31:0] mem [256];
  int          stb_age     = 0;
  int          acks_given  = 0;
  int          ack_limit   = 0;
  int          wait_states = 0;
  logic        corrupt_en  = 1'b0;
  logic        bad_b_en    = 1'b0;
  logic [24:0] bad_a       = 25'd0;
  logic [24:0] bad_b       = 25'd0;
  int          cyc         = 0;

  assign ack     = stb && (acks_given < ack_limit) && (stb_age >= wait_states);
  assign data_in = mem[addr[7:0]] ^
                   {31'b0, corrupt_en && ((addr == bad_a) || (bad_b_en && (addr == bad_b)))};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)             stb_age <= 0;
    else if (stb && !ack)   stb_age <= stb_age + 1;
    else                    stb_age <= 0;
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (stb && ack) begin
      acks_given <= acks_given + 1;
      if (we) mem[addr[7:0]] <= data_out;
    end
  end

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  typedef struct {
    int          id;
    int          start_cyc;
    int          lat;
    bit          pass;
    bit          tmo;
    int          errs;
    logic [24:0] eaddr;
  } res_t;

  typedef struct {
    bit          we;
    logic [24:0] a;
    logic [31:0] d;
  } acc_t;

  res_t exp_q[$];
  acc_t acc_q[$];
  int   n_cmp   = 0;
  int   n_fail  = 0;
  int   test_id = 0;

  function automatic logic [31:0] pattern(input logic [24:0] a);
    return {7'b0, a} ^ SEED_TB;
  endfunction

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, want, $time);
    end
  endtask

  // Per-test result monitor
  res_t mon_r;
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 expected no pending test");
      end else begin
        mon_r = exp_q.pop_front();
        check("pass", {31'b0, pass}, {31'b0, mon_r.pass});
        check("timeout", {31'b0, timeout}, {31'b0, mon_r.tmo});
        check("err_cnt", {16'b0, err_cnt}, mon_r.errs);
        check("err_addr", {7'b0, err_addr}, {7'b0, mon_r.eaddr});
        check("latency", cyc - mon_r.start_cyc + 1, mon_r.lat);
        check("busy_at_done", {31'b0, busy}, 32'd0);
        $display("test %0d: pass=%0b timeout=%0b err_cnt=%0d err_addr=%07h latency=%0d",
                 mon_r.id, pass, timeout, err_cnt, err_addr, cyc - mon_r.start_cyc + 1);
      end
    end
  end

  // Per-access bus monitor
  acc_t mon_a;
  always @(negedge clk) begin
    if (rst_n && stb && ack) begin
      if (acc_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_access: got we=%0b addr=%07h expected none", we, addr);
      end else begin
        mon_a = acc_q.pop_front();
        check("acc_we", {31'b0, we}, {31'b0, mon_a.we});
        check("acc_addr", {7'b0, addr}, {7'b0, mon_a.a});
        if (mon_a.we) check("acc_wdata", data_out, mon_a.d);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  // k < 0: RAM acks every access; k >= 0: RAM acks only the first k accesses.
  task automatic issue_test(input logic [24:0] b, input int l, input int w, input int k,
                            input bit cor, input logic [24:0] ba, input bit bben,
                            input logic [24:0] bb,
                            output int lat_o, output bit tmo_o, output bit pass_o);
    int          n_acc;
    int          lim;
    int          idx;
    res_t        r;
    acc_t        a;
    logic [24:0] off_a;
    logic [24:0] off_b;
    bit          in_a;
    bit          in_b;
    n_acc = 2 * PASSES * l;
    lim   = (k < 0) ? n_acc : k;
    idx   = 0;
    for (int p = 0; p < PASSES; p++) begin
      for (int ph = 0; ph < 2; ph++) begin
        for (int i = 0; i < l; i++) begin
          a.we = (ph == 0);
          a.a  = b + 25'(i);
          a.d  = a.we ? ((p == 0) ? pattern(a.a) : ~pattern(a.a)) : 32'h0;
          if (idx < lim) acc_q.push_back(a);
          idx++;
        end
      end
    end
    off_a   = ba - b;
    off_b   = bb - b;
    in_a    = cor && (off_a < 25'(l));
    in_b    = cor && bben && (off_b < 25'(l));
    r.tmo   = (k >= 0);
    r.errs  = r.tmo ? 0 : PASSES * (int'(in_a) + int'(in_b));
    if (r.tmo)                                  r.eaddr = 25'd0;
    else if (in_a && (!in_b || off_a < off_b))  r.eaddr = ba;
    else if (in_b)                              r.eaddr = bb;
    else                                        r.eaddr = 25'd0;
    r.pass  = !r.tmo && (r.errs == 0);
    r.lat   = r.tmo ? (k * (w + 2) + TO + 2) : ((l == 0) ? 2 : n_acc * (w + 2) + 1);
    r.id    = test_id;
    test_id++;

    @(negedge clk);
    wait_states = w;
    corrupt_en  = cor;
    bad_a       = ba;
    bad_b       = bb;
    bad_b_en    = bben;
    ack_limit   = acks_given + lim;
    r.start_cyc = cyc + 1;
    exp_q.push_back(r);
    start = 1'b1;
    base  = b;
    len   = 25'(l);
    @(negedge clk);
    start = 1'b0;
    lat_o  = r.lat;
    tmo_o  = r.tmo;
    pass_o = r.pass;
  endtask

  // Waits (bounded) for done. With poke set, it pulses start with junk
  // operands while the test is busy.
  task automatic wait_done(input int lat, input bit poke, input bit tmo, input bit pss);
    bit got;
    got = 1'b0;
    for (int c = 0; c < lat + 20 && !got; c++) begin
      @(negedge clk);
      if (done) got = 1'b1;
      start = poke && !got && busy && (c == 3);
      if (start) begin
        base = 25'($urandom);
        len  = 25'($urandom);
      end
    end
    start = 1'b0;
    if (!got) begin
      n_cmp++;
      n_fail++;
      $display("FAIL done_wait: got no done expected one within %0d cycles", lat + 20);
    end else begin
      repeat (2) @(negedge clk);
      check("sticky_timeout", {31'b0, timeout}, {31'b0, tmo});
      check("held_pass", {31'b0, pass}, {31'b0, pss});
      check("accesses_left", acc_q.size(), 0);
      check("idle_busy", {31'b0, busy}, 32'd0);
    end
  endtask

  task automatic run_test(input logic [24:0] b, input int l, input int w, input int k,
                          input bit cor, input logic [24:0] ba, input bit bben,
                          input logic [24:0] bb, input bit poke);
    int lat;
    bit tmo;
    bit pss;
    issue_test(b, l, w, k, cor, ba, bben, bb, lat, tmo, pss);
    wait_done(lat, poke, tmo, pss);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          lat;
    bit          tmo;
    bit          pss;
    bit          found;
    logic [24:0] b;
    logic [24:0] ba;
    logic [24:0] bb;
    int          l;
    int          w;
    int          k;
    bit          cor;
    bit          bben;

    rst_n = 1'b0;
    start = 1'b0;
    base  = 25'd0;
    len   = 25'd0;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_pass", {31'b0, pass}, 32'd0);
    check("rst_timeout", {31'b0, timeout}, 32'd0);
    check("rst_err_cnt", {16'b0, err_cnt}, 32'd0);
    check("rst_err_addr", {7'b0, err_addr}, 32'd0);
    check("rst_stb", {31'b0, stb}, 32'd0);
    check("rst_we", {31'b0, we}, 32'd0);
    check("rst_addr", {7'b0, addr}, 32'd0);
    check("rst_data_out", data_out, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases
    run_test(25'h100, 4, 0, -1, 1'b0, 25'h0, 1'b0, 25'h0, 1'b0);          // basic, 17 cycles
    run_test(25'h100, 4, 0, -1, 1'b1, 25'h102, 1'b0, 25'h0, 1'b0);        // bit 0 stuck
    run_test(25'h100, 4, 0, 0, 1'b0, 25'h0, 1'b0, 25'h0, 1'b0);           // never acked
    run_test(25'h055, 0, 0, -1, 1'b0, 25'h0, 1'b0, 25'h0, 1'b0);          // len 0
    run_test(25'h1FFFFFE, 4, 0, -1, 1'b0, 25'h0, 1'b0, 25'h0, 1'b0);      // address wrap
    run_test(25'h200, 3, TO - 1, -1, 1'b0, 25'h0, 1'b0, 25'h0, 1'b0);     // ack on last allowed cycle
    run_test(25'h300, 5, 1, 3, 1'b0, 25'h0, 1'b0, 25'h0, 1'b0);           // timeout mid-write
    run_test(25'h010, 6, 0, -1, 1'b1, 25'h014, 1'b1, 25'h011, 1'b1);      // two errors, start poked

    // Reset during a read access
    issue_test(25'h040, 6, 0, -1, 1'b0, 25'h0, 1'b0, 25'h0, lat, tmo, pss);
    found = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      @(negedge clk);
      if (stb && !we) found = 1'b1;
    end
    check("read_phase_seen", {31'b0, found}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_stb", {31'b0, stb}, 32'd0);
    check("rst_mid_busy", {31'b0, busy}, 32'd0);
    exp_q.delete();
    acc_q.delete();
    repeat (2) @(negedge clk);
    check("rst_mid_err_cnt", {16'b0, err_cnt}, 32'd0);
    check("rst_mid_addr", {7'b0, addr}, 32'd0);
    exp_q.delete();
    acc_q.delete();
    rst_n = 1'b1;
    @(negedge clk);
    run_test(25'h040, 6, 0, -1, 1'b0, 25'h0, 1'b0, 25'h0, 1'b0);          // recovery

    // Randomised cases
    for (int t = 0; t < 30; t++) begin
      w = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, TO - 1)) : int'($urandom_range(0, 2));
      b = 25'($urandom);
      if ($urandom_range(0, 3) == 0) b = 25'h1FFFFFF - 25'($urandom_range(0, 10));
      if ($urandom_range(0, 4) == 0) begin
        l    = int'($urandom_range(1, 16));
        k    = int'($urandom_range(0, 2 * PASSES * l - 1));
        cor  = 1'b0;
        bben = 1'b0;
        ba   = 25'd0;
        bb   = 25'd0;
      end else begin
        l    = int'($urandom_range(0, 20));
        k    = -1;
        cor  = 1'($urandom_range(0, 1));
        ba   = b + 25'($urandom_range(0, l + 3));
        bb   = b + 25'($urandom_range(0, l + 3));
        bben = 1'($urandom_range(0, 1)) && (bb != ba);
      end
      run_test(b, l, w, k, cor, ba, bben, bb, 1'($urandom_range(0, 3) == 0));
    end

    check("results_left", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
